deser_align_ctrl: RTL

Training-pattern alignment controller for one ISERDESE2/IDELAYE2 receive lane of the TI-ROIC LVDS interface, in the `clk_div` domain beside the lane deserializer. On `start` it sweeps the input delay tap, 0 to 31, and checks the deserialized byte against a fixed training pattern. It centres the delay in the first adequate passing window, and issues BITSLIP pulses to step word phase when no window is found. It reports aligned/fail status and the chosen tap and slip count.

---
 rtl/deser_align_pkg.sv | 36 +++
 rtl/deser_align_ctrl_checker.sv | 37 +++
 rtl/deser_align_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/deser_align_pkg.sv
// deser_align_pkg: shared types, constants and window helpers for the lane alignment controller
package deser_align_pkg;
  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;
  localparam int MAX_SLIP = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_NEXT,
    S_SLIP,
    S_SLIP_WAIT,
    S_CENTER,
    S_CENTER_SETTLE,
    S_DONE,
    S_FAIL
  } align_state_t;

  typedef struct packed {
    logic [TAP_W-1:0] first;
    logic [TAP_W-1:0] last;
    logic             open;
  } align_win_t;

  function automatic logic [TAP_W:0] win_width(align_win_t w);
    return {1'b0, w.last} - {1'b0, w.first} + (TAP_W+1)'(1);
  endfunction

  function automatic logic [TAP_W-1:0] win_center(align_win_t w);
    logic [TAP_W:0] sum;
    sum = {1'b0, w.first} + {1'b0, w.last};
    return sum[TAP_W:1];
  endfunction
endpackage

// File: rtl/deser_align_ctrl_checker.sv
// deser_match_checker: registered pattern compare with a consecutive-match counter
module deser_match_checker #(
  parameter int         CHECK_CNT     = 64,
  parameter logic [7:0] TRAIN_PATTERN = 8'hF0
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       clear,
  input  logic       enable,
  output logic       pass,
  output logic       fail
);
  localparam int CW = $clog2(CHECK_CNT + 1);

  logic          match_q, match_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // compare result feeds the counter; pass on the last needed match, fail on any miss
  always_comb begin
    match_d = data == TRAIN_PATTERN;
    cnt_d   = clear ? '0 : (enable ? (match_q ? cnt_q + CW'(1) : '0) : cnt_q);
    pass    = enable && match_q && cnt_q == CW'(CHECK_CNT - 1);
    fail    = enable && !match_q;
  end

  // compare register and match counter
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/deser_align_ctrl.sv
// deser_align_ctrl: IDELAY tap sweep and BITSLIP word-phase search for one LVDS lane
module deser_align_ctrl
  import deser_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
  parameter int         SETTLE_CYC    = 16,
  parameter int         CHECK_CNT     = 64,
  parameter int         MIN_WIN       = 4,
  parameter int         SLIP_WAIT     = 4
) (
  input  logic             clk_div,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       iserdes_q,
  output logic             bitslip,
  output logic             dly_ld,
  output logic [TAP_W-1:0] dly_tap,
  output logic             busy,
  output logic             aligned,
  output logic             align_fail,
  output logic [TAP_W-1:0] align_tap,
  output logic [2:0]       slip_cnt
);
  localparam int WW = $clog2((SETTLE_CYC > SLIP_WAIT ? SETTLE_CYC : SLIP_WAIT) + 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  align_state_t     state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [2:0]       slip_q, slip_d;
  align_win_t       win_q, win_d, win_n;
  logic [WW-1:0]    wait_q, wait_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             aligned_q, aligned_d;
  logic             fail_q, fail_d;
  logic             bitslip_q, bitslip_d;
  logic             dly_ld_q, dly_ld_d;
  logic [TAP_W-1:0] align_tap_q, align_tap_d;
  logic             chk_pass, chk_fail;
  logic             idle_like, close, qual;

  deser_match_checker #(
    .CHECK_CNT    (CHECK_CNT),
    .TRAIN_PATTERN(TRAIN_PATTERN)
  ) u_checker (
    .clk_div(clk_div),
    .rst_n  (rst_n),
    .data   (iserdes_q),
    .clear  (state_q != S_CHECK),
    .enable (state_q == S_CHECK),
    .pass   (chk_pass),
    .fail   (chk_fail)
  );

  // next-state, counters, window tracking and registered output values
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    slip_d      = slip_q;
    win_d       = win_q;
    wait_d      = wait_q;
    pass_d      = pass_q;
    aligned_d   = aligned_q;
    fail_d      = fail_q;
    align_tap_d = align_tap_q;
    bitslip_d   = 1'b0;
    win_n       = win_q;
    if (pass_q) begin
      win_n.first = win_q.open ? win_q.first : tap_q;
      win_n.last  = tap_q;
      win_n.open  = 1'b1;
    end
    close     = !pass_q || tap_q == LAST_TAP;
    qual      = win_n.open && win_width(win_n) >= (TAP_W+1)'(MIN_WIN);
    idle_like = state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL;
    unique case (state_q)
      S_LOAD: begin
        wait_d  = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        wait_d  = wait_q + WW'(1);
        state_d = wait_q == WW'(SETTLE_CYC - 1) ? S_CHECK : S_SETTLE;
      end
      S_CHECK: begin
        pass_d  = chk_pass;
        state_d = (chk_pass || chk_fail) ? S_NEXT : S_CHECK;
      end
      S_NEXT: begin
        if (close && qual) begin
          win_d   = win_n;
          tap_d   = win_center(win_n);
          state_d = S_CENTER;
        end else begin
          win_d   = close ? '0 : win_n;
          tap_d   = tap_q == LAST_TAP ? tap_q : tap_q + TAP_W'(1);
          state_d = tap_q == LAST_TAP ? S_SLIP : S_LOAD;
        end
      end
      S_SLIP: begin
        tap_d = '0;
        if (slip_q == 3'(MAX_SLIP)) begin
          state_d = S_FAIL;
        end else begin
          bitslip_d = 1'b1;
          slip_d    = slip_q + 3'd1;
          win_d     = '0;
          wait_d    = '0;
          state_d   = S_SLIP_WAIT;
        end
      end
      S_SLIP_WAIT: begin
        wait_d  = wait_q + WW'(1);
        state_d = wait_q == WW'(SLIP_WAIT - 1) ? S_LOAD : S_SLIP_WAIT;
      end
      S_CENTER: begin
        wait_d  = '0;
        state_d = S_CENTER_SETTLE;
      end
      S_CENTER_SETTLE: begin
        wait_d  = wait_q + WW'(1);
        state_d = wait_q == WW'(SETTLE_CYC - 1) ? S_DONE : S_CENTER_SETTLE;
      end
      S_DONE: begin
        aligned_d   = 1'b1;
        align_tap_d = tap_q;
      end
      S_FAIL:  fail_d = 1'b1;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (idle_like && start) begin
      state_d     = S_LOAD;
      tap_d       = '0;
      slip_d      = '0;
      win_d       = '0;
      aligned_d   = 1'b0;
      fail_d      = 1'b0;
      align_tap_d = '0;
    end
    busy_d   = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
    dly_ld_d = state_d == S_LOAD || state_d == S_CENTER || (state_d == S_FAIL && state_q != S_FAIL);
  end

  // state, datapath and output registers; reset clears everything with no trailing pulses
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      slip_q      <= '0;
      win_q       <= '0;
      wait_q      <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      aligned_q   <= 1'b0;
      fail_q      <= 1'b0;
      bitslip_q   <= 1'b0;
      dly_ld_q    <= 1'b0;
      align_tap_q <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      slip_q      <= slip_d;
      win_q       <= win_d;
      wait_q      <= wait_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      aligned_q   <= aligned_d;
      fail_q      <= fail_d;
      bitslip_q   <= bitslip_d;
      dly_ld_q    <= dly_ld_d;
      align_tap_q <= align_tap_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign dly_ld     = dly_ld_q;
  assign dly_tap    = tap_q;
  assign busy       = busy_q;
  assign aligned    = aligned_q;
  assign align_fail = fail_q;
  assign align_tap  = align_tap_q;
  assign slip_cnt   = slip_q;
endmodule
